// File: rtl/mac_vlg_tx_buf.sv
// Store-and-forward TX frame buffer: collects a whole payload plus header, then
// offers it to the MAC (avl/rdy) and streams it out gap-free. Bad frames never leave.
package mac_vlg_tx_buf_pkg;
  typedef struct packed {
    logic [47:0] dst_mac_addr;
    logic [15:0] ethertype;
  } mac_hdr_t;
endpackage

module mac_vlg_tx_buf
  import mac_vlg_tx_buf_pkg::*;
#(
  parameter int DEPTH_LOG2 = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_d,
  input  logic                  in_v,
  input  logic                  in_sof,
  input  logic                  in_eof,
  input  logic                  in_err,
  input  mac_hdr_t              in_hdr,
  output logic                  in_busy,
  output logic [7:0]            tx_d,
  output logic                  tx_v,
  output mac_hdr_t              tx_hdr,
  output logic                  avl,
  input  logic                  rdy,
  output logic [DEPTH_LOG2:0]   len,
  output logic                  drop
);
  localparam int PW = DEPTH_LOG2 + 1;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_DISC, S_AVL, S_RD} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d, len_q, len_d;
  mac_hdr_t        hdr_q, hdr_d;
  logic            tx_v_q, tx_v_d, drop_q, drop_d, rdy_q;
  logic [7:0]      tx_d_q;
  logic            we, re;
  logic [DEPTH_LOG2-1:0] waddr, raddr;
  logic            rdy_edge;

  logic [7:0] mem [2**DEPTH_LOG2];

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      len_q   <= '0;
      hdr_q   <= '0;
      tx_v_q  <= 1'b0;
      drop_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      len_q   <= len_d;
      hdr_q   <= hdr_d;
      tx_v_q  <= tx_v_d;
      drop_q  <= drop_d;
      rdy_q   <= rdy;
    end
  end

  // Payload RAM: synchronous write, registered read (one-cycle latency)
  always_ff @(posedge clk) begin
    if (we && !rst) mem[waddr] <= in_d;
  end

  always_ff @(posedge clk) begin
    if (rst)     tx_d_q <= '0;
    else if (re) tx_d_q <= mem[raddr];
  end

  assign rdy_edge = rdy && !rdy_q;

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    len_d   = len_q;
    hdr_d   = hdr_q;
    tx_v_d  = 1'b0;
    drop_d  = 1'b0;
    we      = 1'b0;
    waddr   = wptr_q[DEPTH_LOG2-1:0];
    re      = 1'b0;
    raddr   = rptr_q[DEPTH_LOG2-1:0];
    case (state_q)
      S_IDLE: begin
        if (in_v && in_sof) begin
          we     = 1'b1;
          waddr  = '0;
          hdr_d  = in_hdr;
          wptr_d = PW'(1);
          if (in_eof) begin
            len_d   = PW'(1);
            state_d = S_AVL;
          end else begin
            state_d = S_WR;
          end
        end
      end
      S_WR: begin
        if (in_v) begin
          if (in_err) begin
            drop_d  = 1'b1;
            state_d = S_IDLE;
          end else if (in_sof) begin
            // A fresh sof abandons the partial frame and restarts at address 0
            drop_d = 1'b1;
            we     = 1'b1;
            waddr  = '0;
            hdr_d  = in_hdr;
            wptr_d = PW'(1);
            if (in_eof) begin
              len_d   = PW'(1);
              state_d = S_AVL;
            end
          end else if (wptr_q[DEPTH_LOG2]) begin
            // RAM already full: this byte would not fit, so the frame is lost
            drop_d  = 1'b1;
            state_d = in_eof ? S_IDLE : S_DISC;
          end else begin
            we     = 1'b1;
            wptr_d = wptr_q + 1'b1;
            if (in_eof) begin
              len_d   = wptr_q + 1'b1;
              state_d = S_AVL;
            end
          end
        end
      end
      S_DISC: begin
        if (in_v && in_eof) state_d = S_IDLE;
      end
      S_AVL: begin
        if (rdy_edge) begin
          re      = 1'b1;
          raddr   = '0;
          rptr_d  = PW'(1);
          tx_v_d  = 1'b1;
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (rptr_q < len_q) begin
          re     = 1'b1;
          rptr_d = rptr_q + 1'b1;
          tx_v_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    avl     = (state_q == S_AVL);
    in_busy = (state_q == S_AVL) || (state_q == S_RD);
    tx_v    = tx_v_q;
    tx_d    = tx_d_q;
    tx_hdr  = hdr_q;
    len     = len_q;
    drop    = drop_q;
  end
endmodule

// File: tb/tb_mac_vlg_tx_buf.sv
// Directed bench for mac_vlg_tx_buf: expected TX bytes queued as frames are
// driven, popped and checked as the DUT streams them.
module tb_mac_vlg_tx_buf;
  import mac_vlg_tx_buf_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_d;
  logic        in_v, in_sof, in_eof, in_err, rdy;
  mac_hdr_t    in_hdr;

  logic        in_busy, tx_v, avl, drop;
  logic [7:0]  tx_d;
  mac_hdr_t    tx_hdr;
  logic [11:0] len;

  logic        in_busy_s, tx_v_s, avl_s, drop_s;
  logic [7:0]  tx_d_s;
  mac_hdr_t    tx_hdr_s;
  logic [4:0]  len_s;

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  mac_vlg_tx_buf #(.DEPTH_LOG2(11)) u_dut (
    .clk(clk), .rst(rst), .in_d(in_d), .in_v(in_v), .in_sof(in_sof),
    .in_eof(in_eof), .in_err(in_err), .in_hdr(in_hdr), .in_busy(in_busy),
    .tx_d(tx_d), .tx_v(tx_v), .tx_hdr(tx_hdr), .avl(avl), .rdy(rdy),
    .len(len), .drop(drop));

  mac_vlg_tx_buf #(.DEPTH_LOG2(4)) u_small (
    .clk(clk), .rst(rst), .in_d(in_d), .in_v(in_v), .in_sof(in_sof),
    .in_eof(in_eof), .in_err(in_err), .in_hdr(in_hdr), .in_busy(in_busy_s),
    .tx_d(tx_d_s), .tx_v(tx_v_s), .tx_hdr(tx_hdr_s), .avl(avl_s), .rdy(rdy),
    .len(len_s), .drop(drop_s));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input bit sof, input bit eof, input bit err);
    in_v = 1'b1; in_d = d; in_sof = sof; in_eof = eof; in_err = err;
    tick();
    in_v = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_err = 1'b0;
  endtask

  // Raise rdy and check the first 'stop' bytes against the scoreboard
  task automatic stream(input int n, input int stop);
    rdy = 1'b1;
    tick();
    chk("avl_fall", avl, 0);
    for (int k = 0; k < stop; k++) begin
      chk("tx_v_on", tx_v, 1);
      if (exp_q.size() == 0) chk("sb_empty", 1, 0);
      else chk("tx_d", tx_d, exp_q.pop_front());
      tick();
    end
    rdy = 1'b0;
    if (stop == n) begin
      chk("tx_v_end", tx_v, 0);
      chk("busy_end", in_busy, 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    mac_hdr_t h1, h3, ha, hb, h6;
    h1 = '{dst_mac_addr: 48'h112233445566, ethertype: 16'h0800};
    h3 = '{dst_mac_addr: 48'h0A0B0C0D0E0F, ethertype: 16'h0806};
    ha = '{dst_mac_addr: 48'hAAAAAAAAAAAA, ethertype: 16'h1111};
    hb = '{dst_mac_addr: 48'hBBBBBBBBBBBB, ethertype: 16'h2222};
    h6 = '{dst_mac_addr: 48'h665544332211, ethertype: 16'h86DD};
    in_d = '0; in_v = 0; in_sof = 0; in_eof = 0; in_err = 0; rdy = 0; in_hdr = '0;

    do_reset();
    chk("rst_avl", avl, 0);
    chk("rst_tx_v", tx_v, 0);
    chk("rst_busy", in_busy, 0);
    chk("rst_drop", drop, 0);
    chk("rst_len", len, 0);
    chk("rst_hdr", tx_hdr, 0);

    // 1: 46-byte frame
    in_hdr = h1;
    for (int i = 0; i < 46; i++) begin
      drive(8'(i), i == 0, i == 45, 0);
      exp_q.push_back(8'(i));
      if (i == 44) chk("t1_avl_early", avl, 0);
    end
    chk("t1_avl", avl, 1);
    chk("t1_len", len, 46);
    chk("t1_busy", in_busy, 1);
    chk("t1_hdr", tx_hdr, h1);
    chk("t1_txv_idle", tx_v, 0);
    stream(46, 46);
    chk("t1_hdr_after", tx_hdr, h1);

    // 2: single-byte frame
    drive(8'hA5, 1, 1, 0);
    exp_q.push_back(8'hA5);
    chk("t2_avl", avl, 1);
    chk("t2_len", len, 1);
    stream(1, 1);

    // 3: error on byte 10, then a clean frame
    in_hdr = h3;
    for (int i = 0; i < 10; i++) drive(8'(8'h40 + i), i == 0, 0, i == 9);
    chk("t3_drop", drop, 1);
    chk("t3_avl", avl, 0);
    tick();
    chk("t3_drop_pulse", drop, 0);
    chk("t3_avl_stay", avl, 0);
    in_hdr = h6;
    for (int i = 0; i < 5; i++) begin
      drive(8'(8'hC0 + i), i == 0, i == 4, 0);
      exp_q.push_back(8'(8'hC0 + i));
    end
    chk("t3_avl2", avl, 1);
    chk("t3_len2", len, 5);
    chk("t3_hdr2", tx_hdr, h6);
    stream(5, 5);

    // 5: second frame offered while AVL is ignored
    in_hdr = ha;
    for (int i = 0; i < 8; i++) begin
      drive(8'(8'h80 + i), i == 0, i == 7, 0);
      exp_q.push_back(8'(8'h80 + i));
    end
    chk("t5_busy", in_busy, 1);
    in_hdr = hb;
    for (int i = 0; i < 4; i++) begin
      drive(8'(8'hE0 + i), i == 0, i == 3, 0);
      chk("t5_no_drop", drop, 0);
    end
    chk("t5_avl", avl, 1);
    chk("t5_len", len, 8);
    chk("t5_hdr", tx_hdr, ha);
    stream(8, 8);

    // 6: reset in the middle of streaming
    in_hdr = h6;
    for (int i = 0; i < 10; i++) begin
      drive(8'(8'h10 + i), i == 0, i == 9, 0);
      exp_q.push_back(8'(8'h10 + i));
    end
    stream(10, 5);
    chk("t6_txv_b5", tx_v, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("t6_txv_rst", tx_v, 0);
    chk("t6_avl_rst", avl, 0);
    chk("t6_busy_rst", in_busy, 0);
    in_hdr = h1;
    for (int i = 0; i < 3; i++) begin
      drive(8'(8'h33 * (i + 1)), i == 0, i == 2, 0);
      exp_q.push_back(8'(8'h33 * (i + 1)));
    end
    chk("t6_avl_new", avl, 1);
    chk("t6_len_new", len, 3);
    stream(3, 3);

    // 4: overflow on the 16-byte instance
    do_reset();
    in_hdr = h3;
    for (int i = 0; i < 20; i++) begin
      drive(8'(i), i == 0, i == 19, 0);
      chk("t4_drop", drop_s, (i == 16) ? 1 : 0);
      chk("t4_avl", avl_s, 0);
    end
    tick();
    chk("t4_avl_after", avl_s, 0);
    chk("t4_busy_after", in_busy_s, 0);
    chk("t4_big_len", len, 20);
    drive(8'h01, 1, 0, 0);
    drive(8'h02, 0, 1, 0);
    chk("t4_next_avl", avl_s, 1);
    chk("t4_next_len", len_s, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
